// File: rtl/inst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_responder
// Purpose  : Word-addressed instruction array with a program-load port. Fetch
//            responses return through a fixed-latency pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] addr,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              err,
    output logic [31:0]       fetch_count
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic [DEPTH_LOG2-1:0] w_ld_idx;
    logic                  w_err;
    logic                  w_unused;

    logic [LATENCY-1:0]    r_pv;
    logic [LATENCY-1:0]    r_pe;
    logic [ADDR_W-1:0]     r_pa [LATENCY];
    logic [DATA_W-1:0]     r_pd [LATENCY];
    logic [31:0]           r_fetch_count;

    assign w_rd_idx = addr[DEPTH_LOG2+1:2];
    assign w_ld_idx = ld_addr[DEPTH_LOG2+1:2];
    assign w_err    = (addr[1:0] != 2'b00) || ((addr >> (DEPTH_LOG2 + 2)) != '0);
    // Loader address bits outside the word index alias by design.
    assign w_unused = ^{ld_addr >> (DEPTH_LOG2 + 2), ld_addr[1:0]};

    // Loads ignore rst so the program can be preloaded while in reset.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            r_mem[w_ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv          <= '0;
            r_pe          <= '0;
            r_fetch_count <= 32'd0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pa[i] <= '0;
                r_pd[i] <= '0;
            end
        end else begin
            // Non-blocking read of r_mem yields pre-write data on a collision.
            r_pv[0] <= ce;
            r_pe[0] <= ce & w_err;
            r_pa[0] <= ce ? addr : '0;
            r_pd[0] <= (ce && !w_err) ? r_mem[w_rd_idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pd[i] <= r_pd[i-1];
            end
            if (ce) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign inst        = r_pd[LATENCY-1];
    assign inst_valid  = r_pv[LATENCY-1];
    assign resp_addr   = r_pa[LATENCY-1];
    assign err         = r_pe[LATENCY-1];
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem_responder
// Purpose  : Scoreboard bench driving LATENCY=1/2/4 instances with one stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_mem_responder;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic        err;
        int          due;
    } exp_t;

    localparam int c_LAT [3] = '{1, 2, 4};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [31:0] addr = '0;
    logic        ld_we = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    logic [31:0] inst_o [3];
    logic        vld_o  [3];
    logic [31:0] ra_o   [3];
    logic        err_o  [3];
    logic [31:0] fc_o   [3];

    exp_t        q [3][$];
    logic [31:0] mem_m [1024];
    int          cyc = 0;
    int          exp_cnt = 0;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    inst_mem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_data(ld_data), .inst(inst_o[0]),
        .inst_valid(vld_o[0]), .resp_addr(ra_o[0]), .err(err_o[0]),
        .fetch_count(fc_o[0]));

    inst_mem_responder #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_data(ld_data), .inst(inst_o[1]),
        .inst_valid(vld_o[1]), .resp_addr(ra_o[1]), .err(err_o[1]),
        .fetch_count(fc_o[1]));

    inst_mem_responder #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_data(ld_data), .inst(inst_o[2]),
        .inst_valid(vld_o[2]), .resp_addr(ra_o[2]), .err(err_o[2]),
        .fetch_count(fc_o[2]));

    task automatic cmp(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s lat=%0d cyc=%0d: got 0x%08h expected 0x%08h",
                     name, c_LAT[k], cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    task automatic chk(input int k);
        exp_t x;
        if (vld_o[k] === 1'b1) begin
            if (q[k].size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_valid lat=%0d cyc=%0d: got valid with addr 0x%08h, expected none",
                         c_LAT[k], cyc, ra_o[k]);
            end else begin
                x = q[k].pop_front();
                cmp("inst", k, inst_o[k], x.data);
                cmp("resp_addr", k, ra_o[k], x.addr);
                cmp("err", k, {31'd0, err_o[k]}, {31'd0, x.err});
                cmp("due_cycle", k, cyc, x.due);
            end
        end else begin
            cmp("bubble_valid", k, {31'd0, vld_o[k]}, 32'd0);
            cmp("bubble_inst", k, inst_o[k], 32'd0);
            cmp("bubble_addr", k, ra_o[k], 32'd0);
            cmp("bubble_err", k, {31'd0, err_o[k]}, 32'd0);
            if (q[k].size() != 0 && q[k][0].due <= cyc) begin
                x = q[k].pop_front();
                nvec++;
                nerr++;
                $display("FAIL missing_resp lat=%0d cyc=%0d: got no valid, expected addr 0x%08h due %0d",
                         c_LAT[k], cyc, x.addr, x.due);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) chk(k);
    end

    // One clock of stimulus; expectations are computed before the load lands.
    task automatic step(input logic r, input logic c, input logic [31:0] a,
                        input logic w, input logic [31:0] la, input logic [31:0] ld);
        exp_t x;
        int   e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) cmp("fetch_count", k, fc_o[k], exp_cnt);
        rst = r; ce = c; addr = a; ld_we = w; ld_addr = la; ld_data = ld;
        e = cyc + 1;
        if (r) begin
            exp_cnt = 0;
            for (int k = 0; k < 3; k++)
                while (q[k].size() > 0 && q[k][q[k].size()-1].due >= e)
                    void'(q[k].pop_back());
        end else if (c) begin
            exp_cnt++;
            x.addr = a;
            x.err  = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
            x.data = x.err ? 32'd0 : mem_m[a[11:2]];
            for (int k = 0; k < 3; k++) begin
                x.due = e + c_LAT[k] - 1;
                q[k].push_back(x);
            end
        end
        if (w) mem_m[la[11:2]] = ld;
    endtask

    task automatic fetch(input logic [31:0] a);
        step(1'b0, 1'b1, a, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h4, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        // Preload while in reset.
        step(1'b1, 1'b0, 32'd0, 1'b1, 32'h0, 32'h11111111);
        step(1'b1, 1'b0, 32'd0, 1'b1, 32'h4, 32'h22222222);
        step(1'b1, 1'b0, 32'd0, 1'b1, 32'h8, 32'h33333333);
        step(1'b1, 1'b0, 32'd0, 1'b1, 32'hC, 32'h44444444);
        idle(2);
        // Back-to-back fetches.
        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
        idle(5);
        // Bubble in the middle.
        fetch(32'h0); idle(1); fetch(32'h8);
        idle(5);
        // Misaligned and out-of-range.
        fetch(32'h00000006); fetch(32'h00001000);
        idle(5);
        // Read/write collision returns old data, next fetch sees new.
        step(1'b0, 1'b1, 32'h4, 1'b1, 32'h4, 32'hDEADBEEF);
        fetch(32'h4);
        idle(5);
        // Mid-stream reset drops in-flight responses; array retained.
        fetch(32'h0); fetch(32'h4);
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        idle(1);
        fetch(32'h0); fetch(32'hC);
        idle(6);
        for (int t = 0; t < 20; t++) begin
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
            idle(1);
        end
        for (int k = 0; k < 3; k++) begin
            if (q[k].size() != 0) begin
                nvec++;
                nerr++;
                $display("FAIL drain lat=%0d: got %0d outstanding, expected 0",
                         c_LAT[k], q[k].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
Instruction-memory responder at the far end of the fetch interface: it services the chip-enable/address stream issued by the program-counter generator and returns instruction words. The block holds a word-addressed instruction array with a write port for program loading. Read responses are fully pipelined with a fixed LATENCY, so the block accepts one new fetch every cycle. Out-of-range and misaligned fetches are flagged.

Parameters:
ADDR_W, 32, fetch/load address width in bits (byte address)
DATA_W, 32, instruction word width in bits
DEPTH_LOG2, 10, log2 of array depth in words (1024 words)
LATENCY, 2, cycles from request edge to inst_valid; legal range 1..4

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, synchronous, active-high
ce  in  1  fetch request enable from PC generator; 1 = request this cycle
addr  in  ADDR_W  fetch byte address
ld_we  in  1  program-load write enable
ld_addr  in  ADDR_W  program-load byte address (word-aligned; bits [1:0] ignored)
ld_data  in  DATA_W  program-load write data
inst  out  DATA_W  returned instruction word
inst_valid  out  1  inst/resp_addr/err valid this cycle
resp_addr  out  ADDR_W  echo of the fetch address that produced this response
err  out  1  response is for a misaligned or out-of-range fetch
fetch_count  out  32  number of fetches accepted since reset

Behaviour:
- Reset (rst=1 at posedge): all pipeline valid bits cleared; inst=0, inst_valid=0, resp_addr=0, err=0, fetch_count=0. In-flight responses are dropped, never delivered. Array contents are not cleared.
- Loads: ld_we=1 at posedge writes ld_data to word ld_addr[DEPTH_LOG2+1:2]; loads are accepted even while rst=1, so the array can be preloaded during reset. ld_addr upper bits beyond the array are ignored (aliasing is the loader's responsibility).
- Request accept: ce=1 and rst=0 at posedge N -> request captured; array word addr[DEPTH_LOG2+1:2] is read at edge N; fetch_count increments (wraps at 2^32).
- Response: outputs for that request appear after edge N+LATENCY-1, i.e. inst_valid=1 in the cycle following edge N+LATENCY-1 (LATENCY=1: valid right after edge N). Exactly one response per accepted request, in request order, one per cycle max.
- ce=0 cycles produce bubbles: inst_valid=0 in the corresponding response slot, inst=0, err=0, resp_addr=0.
- Error: addr[1:0]!=0 or addr[ADDR_W-1:DEPTH_LOG2+2]!=0 -> response with inst_valid=1, err=1, inst=0 (NOP); array not read for that request.
- Read/write collision: request and load to the same word at the same edge -> response returns OLD data (read-before-write); the next fetch sees new data.
- Back-to-back: consecutive ce=1 cycles (addr stepping +4) produce consecutive valid responses with no gaps after the initial LATENCY fill.
- Pipeline is a LATENCY-deep register chain carrying {valid, err, addr, data}; no stall input, no backpressure.
- rst asserted mid-stream: outputs 0 after that edge; first response after rst deassert is the first request accepted after deassert.

Test Plan:
- Preload during reset words 0..3 = 0x11111111,0x22222222,0x33333333,0x44444444; release rst, ce=1 with addr 0,4,8,12 on 4 consecutive edges (LATENCY=2) -> inst_valid high 4 consecutive cycles, inst = 0x11111111..0x44444444, resp_addr 0,4,8,12, err=0, fetch_count=4.
- Interleave ce pattern 1,0,1 at addr 0,x,8 -> responses 0x11111111, bubble (inst_valid=0, inst=0), 0x33333333.
- Fetch addr 0x00000006 then 0x00001000 (DEPTH_LOG2=10) -> both responses inst_valid=1, err=1, inst=0, resp_addr echoed.
- Same edge: ce=1 addr 0x4 and ld_we=1 ld_addr 0x4 ld_data 0xDEADBEEF -> response 0x22222222; next fetch of 0x4 returns 0xDEADBEEF.
- Issue 2 fetches, assert rst for one cycle before any response -> no inst_valid pulses; fetch_count=0; outputs 0; array contents retained (refetch word 0 -> 0x11111111).
- Repeat first scenario with LATENCY=1 and LATENCY=4 -> first inst_valid 1 and 4 edges after the first request edge respectively, same data order.
